// File: rtl/pt_frame_tx.sv
// pt_frame_tx - PT2262-compatible frame transmitter.
//
// Each frame is TRITS tri-state code bits, sent MSB pair first, followed by a
// sync word. The whole frame is sent repeats+1 times back to back.
// The alpha pulse unit is ALPHA_DIV clk cycles.
//   code bit '0'   : H4  L12 H4  L12   (alpha units)
//   code bit '1'   : H12 L4  H12 L4
//   code bit float : H4  L12 H12 L4
//   sync           : H4  L124
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   transmission request, sampled only in IDLE
//   ad       in   [2*TRITS-1:0] trit vector (00='0', 01='1', 1x=float)
//   repeats  in   [REPEAT_W-1:0] extra frames after the first
//   abort    in   (only with PT_ABORT_EN) ends an in-flight transmission
//   busy     out  high while frames are being sent
//   done     out  one-cycle pulse after the last frame
//   q        out  registered encoder output
//
// Build option: define PT_ABORT_EN to add the abort input.
module pt_frame_tx #(
   parameter int unsigned TRITS     = 12,
   parameter int unsigned ALPHA_DIV = 4,
   parameter int unsigned REPEAT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2*TRITS-1:0]    ad,
   input  logic [REPEAT_W-1:0]   repeats,
`ifdef PT_ABORT_EN
   input  logic                  abort,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  q
);

   localparam int unsigned IDX_W = (TRITS > 1) ? $clog2(TRITS) : 1;
   localparam int unsigned PRE_W = (ALPHA_DIV > 1) ? $clog2(ALPHA_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_TRIT, S_SYNC, S_DONE} state_e;

   state_e               state_q, state_d;
   logic [2*TRITS-1:0]   ad_q, ad_d;
   logic [REPEAT_W-1:0]  rep_q, rep_d;
   logic [REPEAT_W-1:0]  frame_q, frame_d;
   logic [IDX_W-1:0]     trit_idx_q, trit_idx_d;
   logic [PRE_W-1:0]     pre_q, pre_d;
   logic [6:0]           cnt_q, cnt_d;
   logic [1:0]           seg_q, seg_d;
   logic                 q_q, q_d;

   logic [1:0]           trit_sel;
   logic [6:0]           seg_len;
   logic                 alpha_tick;
   logic                 abort_req;

`ifdef PT_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Trit index counts up from 0; index 0 selects the MSB pair.
   assign trit_sel   = ad_q[2*(TRITS-1-int'(trit_idx_q)) +: 2];
   assign alpha_tick = (pre_q == PRE_W'(ALPHA_DIV-1));

   // Length in alpha of the current segment. Every waveform alternates
   // high/low starting high, so only the lengths depend on the symbol.
   always_comb begin
      seg_len = 7'd4;
      if (state_q == S_SYNC) begin
         seg_len = seg_q[0] ? 7'd124 : 7'd4;
      end else begin
         case (trit_sel)
            2'b00:   seg_len = seg_q[0] ? 7'd12 : 7'd4;
            2'b01:   seg_len = seg_q[0] ? 7'd4  : 7'd12;
            default: seg_len = (seg_q == 2'd1 || seg_q == 2'd2) ? 7'd12 : 7'd4;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      ad_d       = ad_q;
      rep_d      = rep_q;
      frame_d    = frame_q;
      trit_idx_d = trit_idx_q;
      pre_d      = pre_q;
      cnt_d      = cnt_q;
      seg_d      = seg_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ad_d       = ad;
               rep_d      = repeats;
               frame_d    = '0;
               trit_idx_d = '0;
               pre_d      = '0;
               cnt_d      = '0;
               seg_d      = '0;
               state_d    = S_TRIT;
            end
         end
         S_TRIT, S_SYNC: begin
            pre_d = alpha_tick ? '0 : pre_q + 1'b1;
            if (alpha_tick) begin
               if (cnt_q == seg_len - 7'd1) begin
                  cnt_d = '0;
                  if (state_q == S_TRIT) begin
                     if (seg_q == 2'd3) begin
                        seg_d = '0;
                        if (trit_idx_q == IDX_W'(TRITS-1)) begin
                           trit_idx_d = '0;
                           state_d    = S_SYNC;
                        end else begin
                           trit_idx_d = trit_idx_q + 1'b1;
                        end
                     end else begin
                        seg_d = seg_q + 1'b1;
                     end
                  end else begin
                     if (seg_q == 2'd1) begin
                        seg_d = '0;
                        if (frame_q < rep_q) begin
                           frame_d = frame_q + 1'b1;
                           state_d = S_TRIT;
                        end else begin
                           state_d = S_DONE;
                        end
                     end else begin
                        seg_d = seg_q + 1'b1;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
            if (abort_req) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // q is registered: drive the level of the position being entered.
      q_d = ((state_d == S_TRIT) || (state_d == S_SYNC)) && !seg_d[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ad_q       <= '0;
         rep_q      <= '0;
         frame_q    <= '0;
         trit_idx_q <= '0;
         pre_q      <= '0;
         cnt_q      <= '0;
         seg_q      <= '0;
         q_q        <= 1'b0;
      end else begin
         state_q    <= state_d;
         ad_q       <= ad_d;
         rep_q      <= rep_d;
         frame_q    <= frame_d;
         trit_idx_q <= trit_idx_d;
         pre_q      <= pre_d;
         cnt_q      <= cnt_d;
         seg_q      <= seg_d;
         q_q        <= q_d;
      end
   end

   assign busy = (state_q == S_TRIT) || (state_q == S_SYNC);
   assign done = (state_q == S_DONE);
   assign q    = q_q;

endmodule

// File: tb/tb_pt_frame_tx.sv
module tb_pt_frame_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // dut_a: TRITS=2, ALPHA_DIV=1, REPEAT_W=4
   logic       start_a = 1'b0;
   logic [3:0] ad_a    = '0;
   logic [3:0] rep_a   = '0;
   logic       busy_a, done_a, q_a;
   // dut_b: TRITS=1, ALPHA_DIV=2, REPEAT_W=2
   logic       start_b = 1'b0;
   logic [1:0] ad_b    = '0;
   logic [1:0] rep_b   = '0;
   logic       busy_b, done_b, q_b;
`ifdef PT_ABORT_EN
   logic       abort_a = 1'b0;
   logic       abort_b = 1'b0;
`endif

   int tests = 0;
   int fails = 0;

   pt_frame_tx #(.TRITS(2), .ALPHA_DIV(1), .REPEAT_W(4)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .ad(ad_a), .repeats(rep_a),
`ifdef PT_ABORT_EN
      .abort(abort_a),
`endif
      .busy(busy_a), .done(done_a), .q(q_a));

   pt_frame_tx #(.TRITS(1), .ALPHA_DIV(2), .REPEAT_W(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .ad(ad_b), .repeats(rep_b),
`ifdef PT_ABORT_EN
      .abort(abort_b),
`endif
      .busy(busy_b), .done(done_b), .q(q_b));

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic cur_busy(input int sel);
      return (sel == 0) ? busy_a : busy_b;
   endfunction
   function automatic logic cur_done(input int sel);
      return (sel == 0) ? done_a : done_b;
   endfunction
   function automatic logic cur_q(input int sel);
      return (sel == 0) ? q_a : q_b;
   endfunction

   // Expected q at cycle k after busy rises, from the symbol tables.
   function automatic logic model_q(input logic [3:0] adv, input int trits,
                                    input int alpha, input int k);
      int p;
      int off;
      logic [3:0] sh;
      logic [1:0] t;
      p = (k / alpha) % (32 * trits + 128);
      if (p < 32 * trits) begin
         sh  = adv >> (2 * (trits - 1 - p / 32));
         t   = sh[1:0];
         off = p % 32;
         case (t)
            2'b00:   return (off < 4)  || (off >= 16 && off < 20);
            2'b01:   return (off < 12) || (off >= 16 && off < 28);
            default: return (off < 4)  || (off >= 16 && off < 28);
         endcase
      end
      return (p - 32 * trits) < 4;
   endfunction

   // mode 1: at cycle 20 change ad to 1111 and pulse start (must be ignored)
   task automatic run(input int sel, input logic [3:0] adv, input logic [3:0] rep,
                      input int exp_len, input int exp_ones, input int mode,
                      input string name);
      int trits;
      int alpha;
      int k;
      int ones;
      int qerr;
      int dn;
      trits = (sel == 0) ? 2 : 1;
      alpha = (sel == 0) ? 1 : 2;
      k = 0; ones = 0; qerr = 0; dn = 0;
      @(negedge clk);
      if (sel == 0) begin
         ad_a = adv; rep_a = rep; start_a = 1'b1;
      end else begin
         ad_b = adv[1:0]; rep_b = rep[1:0]; start_b = 1'b1;
      end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      while (cur_busy(sel) && k < 20000) begin
         if (cur_q(sel) !== model_q(adv, trits, alpha, k)) qerr++;
         if (cur_q(sel)) ones++;
         if (cur_done(sel)) dn++;
         if (mode == 1 && k == 20) begin
            ad_a = 4'b1111; start_a = 1'b1;
         end
         if (mode == 1 && k == 21) start_a = 1'b0;
         k++;
         @(negedge clk);
      end
      check({name, " busy_len"}, k, exp_len);
      check({name, " q_wave_errs"}, qerr, 0);
      check({name, " q_ones"}, ones, exp_ones);
      check({name, " done_while_busy"}, dn, 0);
      check({name, " done_pulse"}, int'(cur_done(sel)), 1);
      check({name, " q_at_done"}, int'(cur_q(sel)), 0);
      @(negedge clk);
      check({name, " done_clear"}, int'(cur_done(sel)), 0);
      check({name, " idle_busy"}, int'(cur_busy(sel)), 0);
   endtask

   typedef struct {
      logic [3:0] ad;
      logic [3:0] rep;
      int         exp_len;
      int         exp_ones;
      int         mode;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int bad;
      int k;
      // dut_a: frame = 192 cycles; ones per trit '0'=8, '1'=24, float=16, sync=4
      vecs[0] = '{4'b0001, 4'd0,  192,  36, 1};
      vecs[1] = '{4'b1010, 4'd1,  384,  72, 0};
      vecs[2] = '{4'b0100, 4'd0,  192,  36, 0};
      vecs[3] = '{4'b1100, 4'd2,  576,  84, 0};
      vecs[4] = '{4'b0101, 4'd0,  192,  52, 0};
      vecs[5] = '{4'b0000, 4'd0,  192,  20, 0};
      vecs[6] = '{4'b1101, 4'd0,  192,  44, 0};
      vecs[7] = '{4'b0000, 4'd15, 3072, 320, 0};

      // Reset and idle
      repeat (3) @(negedge clk);
      check("reset q", int'(q_a), 0);
      check("reset busy", int'(busy_a), 0);
      check("reset done", int'(done_a), 0);
      rst = 1'b0;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (q_a || busy_a || done_a || q_b || busy_b || done_b) bad++;
      end
      check("idle outputs", bad, 0);

      for (int i = 0; i < 8; i++) begin
         run(0, vecs[i].ad, vecs[i].rep, vecs[i].exp_len, vecs[i].exp_ones,
             vecs[i].mode, $sformatf("vec%0d", i));
      end

      // Float with repeats, and repeats all-ones (2^REPEAT_W frames)
      run(1, 4'b0010, 4'd2, 960, 120, 0, "b_float_rep2");
      run(1, 4'b0001, 4'd3, 1280, 224, 0, "b_rep_max");

      // Mid-frame asynchronous reset
      @(negedge clk);
      ad_a = 4'b0001; rep_a = 4'd0; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (49) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst q", int'(q_a), 0);
      check("midrst busy", int'(busy_a), 0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_a) bad++;
      end
      check("midrst no done", bad, 0);
      rst = 1'b0;
      run(0, 4'b0001, 4'd0, 192, 36, 0, "after_rst");

      // start held high: restart on the IDLE cycle after DONE
      @(negedge clk);
      ad_a = 4'b0000; rep_a = 4'd0; start_a = 1'b1;
      @(negedge clk);
      k = 0;
      while (busy_a && k < 1000) begin
         k++;
         @(negedge clk);
      end
      check("held busy_len", k, 192);
      check("held done", int'(done_a), 1);
      @(negedge clk);
      check("held idle gap", int'(busy_a), 0);
      @(negedge clk);
      check("held restart", int'(busy_a), 1);
      start_a = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

`ifdef PT_ABORT_EN
      @(negedge clk);
      ad_a = 4'b0101; rep_a = 4'd3; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (40) @(negedge clk);
      abort_a = 1'b1; start_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0; start_a = 1'b0;
      check("abort q", int'(q_a), 0);
      check("abort done", int'(done_a), 1);
      check("abort busy", int'(busy_a), 0);
      @(negedge clk);
      check("abort done clear", int'(done_a), 0);
      @(negedge clk);
      check("abort start ignored", int'(busy_a), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
